// File: rtl/issue_queue_if.sv
// Issue queue control-word layout and decode/issue bus interface.
// Optional performance counters appear when ISSUE_QUEUE_PERF_EN is defined.
`ifndef CTRL_BUS
`define CTRL_BUS [19:0]
`endif

package issue_queue_pkg;
    localparam int unsigned INST_W = 32;
    localparam int unsigned CTRL_W = 20;

    typedef struct packed {
        logic       issue_slot;
        logic       issue_pri;
        logic [4:0] rs2;
        logic       rs2_active;
        logic [4:0] rs1;
        logic       rs1_active;
        logic [4:0] rd;
        logic       regwrite;
    } ctrl_t;
endpackage

interface issue_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic              in_valid0_i;
    logic              in_valid1_i;
    logic [31:0]       in_inst0_i;
    logic [31:0]       in_inst1_i;
    logic `CTRL_BUS    in_ctrl0_i;
    logic `CTRL_BUS    in_ctrl1_i;
    logic              in_ready_o;
    logic              flush_i;
    logic              ex_stall_i;
    logic              issued_valid0_o;
    logic              issued_valid1_o;
    logic [31:0]       issued_inst0_o;
    logic [31:0]       issued_inst1_o;
    logic `CTRL_BUS    issued_ctrl0_o;
    logic `CTRL_BUS    issued_ctrl1_o;
    logic [PTR_W-1:0]  count_o;
`ifdef ISSUE_QUEUE_PERF_EN
    logic [CNT_W-1:0]  dual_cnt_o;
    logic [CNT_W-1:0]  single_cnt_o;
    logic [CNT_W-1:0]  stall_cnt_o;
`endif

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W == 0) begin : g_param_check
        $error("issue_queue_if: DEPTH must be a power of two >= 4 and CNT_W nonzero");
    end

    modport master (
        output in_valid0_i, in_valid1_i, in_inst0_i, in_inst1_i, in_ctrl0_i, in_ctrl1_i,
        output flush_i, ex_stall_i,
        input  in_ready_o, issued_valid0_o, issued_valid1_o, issued_inst0_o, issued_inst1_o,
        input  issued_ctrl0_o, issued_ctrl1_o, count_o
`ifdef ISSUE_QUEUE_PERF_EN
        , input dual_cnt_o, single_cnt_o, stall_cnt_o
`endif
    );

    modport slave (
        input  in_valid0_i, in_valid1_i, in_inst0_i, in_inst1_i, in_ctrl0_i, in_ctrl1_i,
        input  flush_i, ex_stall_i,
        output in_ready_o, issued_valid0_o, issued_valid1_o, issued_inst0_o, issued_inst1_o,
        output issued_ctrl0_o, issued_ctrl1_o, count_o
`ifdef ISSUE_QUEUE_PERF_EN
        , output dual_cnt_o, single_cnt_o, stall_cnt_o
`endif
    );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue in-order issue queue: circular buffer feeding two execution pipes.
// Define ISSUE_QUEUE_PERF_EN to add dual/single/stall performance counters.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic         clock_i,
    input  logic         reset_i,
    issue_queue_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        ctrl_t             ctrl;
    } entry_t;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W == 0) begin : g_param_check
        $error("issue_queue: DEPTH must be a power of two >= 4 and CNT_W nonzero");
    end

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q, cnt_q;
    logic [PTR_W-1:0] head1_c, tail1_c;
    logic             ready_c, push0_c, push1_c;
    logic [1:0]       push_n_c, pop_n_c, pop_c;
    entry_t           ent_a_c, ent_b_c;
    logic             a_vld_c, b_vld_c, dep_c, collide_c, pair_c, a_to_pipe1_c;
    logic             nv0_c, nv1_c;
    entry_t           n0_c, n1_c;
    logic             iss_v0_q, iss_v1_q;
    entry_t           iss0_q, iss1_q;

    // Enqueue side: a pair is accepted only when two slots are guaranteed free.
    assign ready_c  = (PTR_W'(DEPTH) - cnt_q) >= PTR_W'(2);
    assign push0_c  = ready_c && bus.in_valid0_i;
    assign push1_c  = push0_c && bus.in_valid1_i;
    assign push_n_c = {1'b0, push0_c} + {1'b0, push1_c};
    assign tail1_c  = tail_q + PTR_W'(1);
    assign head1_c  = head_q + PTR_W'(1);

    assign ent_a_c = mem[head_q[IDX_W-1:0]];
    assign ent_b_c = mem[head1_c[IDX_W-1:0]];

    // Pair selection: RAW hazard and pipe collision both force single issue.
    always_comb begin
        a_vld_c   = cnt_q != '0;
        b_vld_c   = cnt_q >= PTR_W'(2);
        dep_c     = ent_a_c.ctrl.regwrite && (ent_a_c.ctrl.rd != '0) &&
                    ((ent_b_c.ctrl.rs1_active && (ent_b_c.ctrl.rs1 == ent_a_c.ctrl.rd)) ||
                     (ent_b_c.ctrl.rs2_active && (ent_b_c.ctrl.rs2 == ent_a_c.ctrl.rd)));
        collide_c = ent_a_c.ctrl.issue_pri && ent_b_c.ctrl.issue_pri &&
                    (ent_a_c.ctrl.issue_slot == ent_b_c.ctrl.issue_slot);
        pair_c    = b_vld_c && !dep_c && !collide_c;
        pop_n_c   = pair_c ? 2'd2 : (a_vld_c ? 2'd1 : 2'd0);
        pop_c     = bus.ex_stall_i ? 2'd0 : pop_n_c;
    end

    // Steering onto pipes A/B.
    always_comb begin
        nv0_c        = 1'b0;
        nv1_c        = 1'b0;
        n0_c         = ent_a_c;
        n1_c         = ent_b_c;
        a_to_pipe1_c = ent_a_c.ctrl.issue_pri ? ent_a_c.ctrl.issue_slot
                                              : (ent_b_c.ctrl.issue_pri && !ent_b_c.ctrl.issue_slot);
        if (pair_c) begin
            nv0_c = 1'b1;
            nv1_c = 1'b1;
            if (a_to_pipe1_c) begin
                n0_c = ent_b_c;
                n1_c = ent_a_c;
            end
        end else if (a_vld_c) begin
            if (ent_a_c.ctrl.issue_pri && ent_a_c.ctrl.issue_slot) begin
                nv1_c = 1'b1;
                n1_c  = ent_a_c;
            end else begin
                nv0_c = 1'b1;
            end
        end
    end

    // Storage needs no reset; pushes are dropped on reset and flush.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !bus.flush_i) begin
            if (push0_c) mem[tail_q[IDX_W-1:0]]  <= '{inst: bus.in_inst0_i, ctrl: ctrl_t'(bus.in_ctrl0_i)};
            if (push1_c) mem[tail1_c[IDX_W-1:0]] <= '{inst: bus.in_inst1_i, ctrl: ctrl_t'(bus.in_ctrl1_i)};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            iss_v0_q <= 1'b0;
            iss_v1_q <= 1'b0;
            iss0_q   <= '0;
            iss1_q   <= '0;
        end else if (bus.flush_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            iss_v0_q <= 1'b0;
            iss_v1_q <= 1'b0;
        end else begin
            tail_q <= tail_q + PTR_W'(push_n_c);
            head_q <= head_q + PTR_W'(pop_c);
            cnt_q  <= cnt_q + PTR_W'(push_n_c) - PTR_W'(pop_c);
            if (!bus.ex_stall_i) begin
                iss_v0_q <= nv0_c;
                iss_v1_q <= nv1_c;
                iss0_q   <= n0_c;
                iss1_q   <= n1_c;
            end
        end
    end

    assign bus.in_ready_o      = ready_c;
    assign bus.count_o         = cnt_q;
    assign bus.issued_valid0_o = iss_v0_q;
    assign bus.issued_valid1_o = iss_v1_q;
    assign bus.issued_inst0_o  = iss0_q.inst;
    assign bus.issued_inst1_o  = iss1_q.inst;
    assign bus.issued_ctrl0_o  = iss0_q.ctrl;
    assign bus.issued_ctrl1_o  = iss1_q.ctrl;

`ifdef ISSUE_QUEUE_PERF_EN
    logic [CNT_W-1:0] dual_q, single_q, stall_q;
    logic             fire_c;

    assign fire_c = !bus.flush_i && !bus.ex_stall_i;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            dual_q   <= '0;
            single_q <= '0;
            stall_q  <= '0;
        end else begin
            if (fire_c && pair_c)                dual_q   <= dual_q + CNT_W'(1);
            if (fire_c && a_vld_c && !pair_c)    single_q <= single_q + CNT_W'(1);
            if (a_vld_c && !fire_c)              stall_q  <= stall_q + CNT_W'(1);
        end
    end

    assign bus.dual_cnt_o   = dual_q;
    assign bus.single_cnt_o = single_q;
    assign bus.stall_cnt_o  = stall_q;
`endif
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: vector table with an expectation scoreboard,
// plus hand sequences for stall/fill/drain, flush and the optional counters.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 32;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct {
        string       name;
        logic        p0;
        logic        p1;
        logic [31:0] i0;
        ctrl_t       c0;
        logic [31:0] i1;
        ctrl_t       c1;
        exp_t        e1;
        exp_t        e2;
    } vec_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [31:0] order_q[$];
    vec_t vecs[15];

    always #5 clock_i = ~clock_i;

    issue_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    function automatic ctrl_t mk(logic rw, logic [4:0] rd, logic r1a, logic [4:0] rs1,
                                 logic r2a, logic [4:0] rs2, logic pri, logic slot);
        ctrl_t c;
        c.regwrite   = rw;
        c.rd         = rd;
        c.rs1_active = r1a;
        c.rs1        = rs1;
        c.rs2_active = r2a;
        c.rs2        = rs2;
        c.issue_pri  = pri;
        c.issue_slot = slot;
        return c;
    endfunction

    function automatic exp_t ex(logic v0, logic v1, logic [31:0] i0, logic [31:0] i1, logic [3:0] cnt);
        exp_t e;
        e.v0 = v0; e.v1 = v1; e.i0 = i0; e.i1 = i1; e.cnt = cnt;
        return e;
    endfunction

    function automatic vec_t mv(string n, logic p0, logic p1, logic [31:0] i0, ctrl_t c0,
                                logic [31:0] i1, ctrl_t c1, exp_t e1, exp_t e2);
        vec_t v;
        v.name = n; v.p0 = p0; v.p1 = p1; v.i0 = i0; v.c0 = c0; v.i1 = i1; v.c1 = c1;
        v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(logic v0, logic v1, logic [31:0] i0, ctrl_t c0, logic [31:0] i1, ctrl_t c1);
        bus.in_valid0_i = v0;
        bus.in_valid1_i = v1;
        bus.in_inst0_i  = i0;
        bus.in_ctrl0_i  = c0;
        bus.in_inst1_i  = i1;
        bus.in_ctrl1_i  = c1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, '0, 32'h0, '0);
    endtask

    task automatic check_pop(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".v0"}, 32'(bus.issued_valid0_o), 32'(e.v0));
        chk({tag, ".v1"}, 32'(bus.issued_valid1_o), 32'(e.v1));
        chk({tag, ".cnt"}, 32'(bus.count_o), 32'(e.cnt));
        if (e.v0) chk({tag, ".inst0"}, bus.issued_inst0_o, e.i0);
        if (e.v1) chk({tag, ".inst1"}, bus.issued_inst1_o, e.i1);
    endtask

    // Bench-side record of program order; the DUT output must match it pipe0-first.
    task automatic check_order(string tag);
        logic [31:0] w;
        if (bus.issued_valid0_o) begin
            w = (order_q.size() != 0) ? order_q.pop_front() : 32'hDEAD_DEAD;
            chk({tag, ".inst0"}, bus.issued_inst0_o, w);
        end
        if (bus.issued_valid1_o) begin
            w = (order_q.size() != 0) ? order_q.pop_front() : 32'hDEAD_DEAD;
            chk({tag, ".inst1"}, bus.issued_inst1_o, w);
        end
    endtask

    task automatic drain(string tag, int unsigned start_cnt);
        int unsigned c;
        c = start_cnt;
        bus.ex_stall_i = 1'b0;
        for (int k = 0; k < 8 && c != 0; k++) begin
            step();
            c = (c >= 2) ? c - 2 : 0;
            chk($sformatf("%s.cnt%0d", tag, k), 32'(bus.count_o), 32'(c));
            chk($sformatf("%s.pair%0d", tag, k), 32'(bus.issued_valid0_o && bus.issued_valid1_o),
                32'(c + 2 <= start_cnt - 2 * k ? 1 : 0));
            check_order($sformatf("%s.d%0d", tag, k));
        end
        chk({tag, ".leftover"}, 32'(order_q.size()), 32'd0);
    endtask

    localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
    localparam logic [31:0] ADDI_X2 = 32'h0020_0113;
    localparam logic [31:0] ADD_X3  = 32'h0010_81B3;
    localparam logic [31:0] IA      = 32'hA000_0001;
    localparam logic [31:0] IB      = 32'hB000_0002;

    initial begin
        ctrl_t c_x1, c_x2, c_add, c_none, c_p0, c_p1;
        logic [31:0] w;
        c_x1   = mk(1, 1, 1, 0, 0, 0, 0, 0);
        c_x2   = mk(1, 2, 1, 0, 0, 0, 0, 0);
        c_add  = mk(1, 3, 1, 1, 1, 1, 0, 0);
        c_none = mk(0, 0, 0, 0, 0, 0, 0, 0);
        c_p0   = mk(0, 0, 0, 0, 0, 0, 1, 0);
        c_p1   = mk(0, 0, 0, 0, 0, 0, 1, 1);

        vecs[0]  = mv("dual_indep", 1, 1, ADDI_X1, c_x1, ADDI_X2, c_x2,
                      ex(1, 1, ADDI_X1, ADDI_X2, 0), ex(0, 0, 0, 0, 0));
        vecs[1]  = mv("raw_dep", 1, 1, ADDI_X1, c_x1, ADD_X3, c_add,
                      ex(1, 0, ADDI_X1, 0, 1), ex(1, 0, ADD_X3, 0, 0));
        vecs[2]  = mv("x0_producer", 1, 1, IA, mk(1, 0, 1, 0, 0, 0, 0, 0), IB, mk(1, 3, 1, 0, 1, 0, 0, 0),
                      ex(1, 1, IA, IB, 0), ex(0, 0, 0, 0, 0));
        vecs[3]  = mv("a_pri1", 1, 1, IA, c_p1, IB, c_none,
                      ex(1, 1, IB, IA, 0), ex(0, 0, 0, 0, 0));
        vecs[4]  = mv("both_pri0", 1, 1, IA, c_p0, IB, c_p0,
                      ex(1, 0, IA, 0, 1), ex(1, 0, IB, 0, 0));
        vecs[5]  = mv("b_pri0", 1, 1, IA, c_none, IB, c_p0,
                      ex(1, 1, IB, IA, 0), ex(0, 0, 0, 0, 0));
        vecs[6]  = mv("pri0_pri1", 1, 1, IA, c_p0, IB, c_p1,
                      ex(1, 1, IA, IB, 0), ex(0, 0, 0, 0, 0));
        vecs[7]  = mv("dep_rs2", 1, 1, IA, mk(1, 5, 0, 0, 0, 0, 0, 0), IB, mk(0, 0, 0, 0, 1, 5, 0, 0),
                      ex(1, 0, IA, 0, 1), ex(1, 0, IB, 0, 0));
        vecs[8]  = mv("no_regwrite", 1, 1, IA, mk(0, 3, 0, 0, 0, 0, 0, 0), IB, mk(0, 0, 1, 3, 0, 0, 0, 0),
                      ex(1, 1, IA, IB, 0), ex(0, 0, 0, 0, 0));
        vecs[9]  = mv("rs1_inactive", 1, 1, IA, mk(1, 4, 0, 0, 0, 0, 0, 0), IB, mk(0, 0, 0, 4, 0, 0, 0, 0),
                      ex(1, 1, IA, IB, 0), ex(0, 0, 0, 0, 0));
        vecs[10] = mv("single_push", 1, 0, IA, c_none, IB, c_none,
                      ex(1, 0, IA, 0, 0), ex(0, 0, 0, 0, 0));
        vecs[11] = mv("slot1_only", 0, 1, IA, c_none, IB, c_none,
                      ex(0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0));
        vecs[12] = mv("both_pri1", 1, 1, IA, c_p1, IB, c_p1,
                      ex(0, 1, 0, IA, 1), ex(0, 1, 0, IB, 0));
        vecs[13] = mv("b_pri1", 1, 1, IA, c_none, IB, c_p1,
                      ex(1, 1, IA, IB, 0), ex(0, 0, 0, 0, 0));
        vecs[14] = mv("dep_a_pri1", 1, 1, IA, mk(1, 6, 0, 0, 0, 0, 1, 1), IB, mk(0, 0, 1, 6, 0, 0, 0, 0),
                      ex(0, 1, 0, IA, 1), ex(1, 0, IB, 0, 0));

        idle();
        bus.flush_i    = 1'b0;
        bus.ex_stall_i = 1'b0;
        reset_i        = 1'b1;
        step();
        step();
        chk("rst.count", 32'(bus.count_o), 32'd0);
        chk("rst.v0", 32'(bus.issued_valid0_o), 32'd0);
        chk("rst.v1", 32'(bus.issued_valid1_o), 32'd0);
        chk("rst.inst0", bus.issued_inst0_o, 32'd0);
        chk("rst.ready", 32'(bus.in_ready_o), 32'd1);
        reset_i = 1'b0;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].p0, vecs[i].p1, vecs[i].i0, vecs[i].c0, vecs[i].i1, vecs[i].c1);
            sb.push_back(vecs[i].e1);
            sb.push_back(vecs[i].e2);
            step();
            idle();
            step();
            check_pop({vecs[i].name, ".c1"});
            step();
            check_pop({vecs[i].name, ".c2"});
`ifdef ISSUE_QUEUE_PERF_EN
            if (i == 1) begin
                chk("perf.dual", bus.dual_cnt_o, 32'd1);
                chk("perf.single", bus.single_cnt_o, 32'd2);
                chk("perf.stall", bus.stall_cnt_o, 32'd0);
            end
`endif
        end

        // Issue a pair, then stall: the issued pair must hold while the queue fills to 7.
        drive(1, 1, 32'hC000_0000, c_none, 32'hC000_0001, c_none);
        step();
        idle();
        step();
        bus.ex_stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 32'hF000_0000 + 32'(2 * k);
            if (k == 0) begin
                drive(1, 0, w, c_none, 32'h0, c_none);
                order_q.push_back(w);
            end else begin
                drive(1, 1, w, c_none, w + 32'd1, c_none);
                order_q.push_back(w);
                order_q.push_back(w + 32'd1);
            end
            step();
            chk($sformatf("fill7.cnt%0d", k), 32'(bus.count_o), 32'(2 * k + 1));
            chk($sformatf("fill7.hold_v%0d", k), 32'({bus.issued_valid0_o, bus.issued_valid1_o}), 32'd3);
            chk($sformatf("fill7.hold_i%0d", k), bus.issued_inst0_o, 32'hC000_0000);
        end
        chk("fill7.ready", 32'(bus.in_ready_o), 32'd0);
        drive(1, 1, 32'hEEEE_0000, c_none, 32'hEEEE_0001, c_none);
        step();
        idle();
        chk("fill7.drop_cnt", 32'(bus.count_o), 32'd7);
        drain("drain7", 7);

        bus.ex_stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 32'hE100_0000 + 32'(2 * k);
            drive(1, 1, w, c_none, w + 32'd1, c_none);
            order_q.push_back(w);
            order_q.push_back(w + 32'd1);
            step();
            chk($sformatf("fill8.cnt%0d", k), 32'(bus.count_o), 32'(2 * k + 2));
        end
        idle();
        chk("fill8.ready", 32'(bus.in_ready_o), 32'd0);
        drain("drain8", 8);

        // Flush at count 5 with a simultaneous push: everything, including the push, is gone.
        bus.ex_stall_i = 1'b1;
        drive(1, 0, 32'hD000_0000, c_none, 32'h0, c_none);
        step();
        drive(1, 1, 32'hD000_0001, c_none, 32'hD000_0002, c_none);
        step();
        step();
        chk("flush.pre_cnt", 32'(bus.count_o), 32'd5);
        drive(1, 1, 32'hD0D0_0000, c_none, 32'hD0D0_0001, c_none);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i    = 1'b0;
        bus.ex_stall_i = 1'b0;
        idle();
        chk("flush.cnt", 32'(bus.count_o), 32'd0);
        chk("flush.valids", 32'({bus.issued_valid0_o, bus.issued_valid1_o}), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("flush.after_cnt%0d", k), 32'(bus.count_o), 32'd0);
            chk($sformatf("flush.after_v%0d", k), 32'({bus.issued_valid0_o, bus.issued_valid1_o}), 32'd0);
        end

`ifdef ISSUE_QUEUE_PERF_EN
        chk("perf.stall_nonzero", 32'(bus.stall_cnt_o != 0), 32'd1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("perf.rst_dual", bus.dual_cnt_o, 32'd0);
        chk("perf.rst_single", bus.single_cnt_o, 32'd0);
        chk("perf.rst_stall", bus.stall_cnt_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
